// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with registered status,
// occupancy count, programmable almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and synchronous flush.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads;
// left undefined, reads have one cycle of latency through a data_out register.
module sync_fifo_param #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int PTR_W     = 3,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             put,
  input  logic [WIDTH-1:0] data_in,
  input  logic             get,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             empty_bar,
  output logic             full_bar,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] AF_T    = AF_THRESH[PTR_W:0];
  localparam logic [PTR_W:0] AE_T    = AE_THRESH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count_q, count_d;
  logic           empty_bar_q, empty_bar_d;
  logic           full_bar_q, full_bar_d;
  logic           almost_full_q, almost_full_d;
  logic           almost_empty_q, almost_empty_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;
  logic           put_acc, get_acc;

  // Acceptance uses the status registered at the start of the cycle; flush wins.
  assign put_acc = put & full_bar_q & ~flush;
  assign get_acc = get & empty_bar_q & ~flush;

  // Next-state pointers, count and flags; status is computed from next-state count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (put_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (get_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    count_d        = wr_ptr_d - rd_ptr_d;
    empty_bar_d    = (wr_ptr_d != rd_ptr_d);
    full_bar_d     = ~((wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                       (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]));
    almost_full_d  = (count_d >= AF_T);
    almost_empty_d = (count_d <= AE_T);
    // A new error in the same cycle as clr_err keeps the flag set.
    overflow_d     = (overflow_q & ~clr_err) | (put & ~full_bar_q);
    underflow_d    = (underflow_q & ~clr_err) | (get & ~empty_bar_q);
  end

  // Pointer, status and error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_bar_q    <= 1'b0;
      full_bar_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_bar_q    <= empty_bar_d;
      full_bar_q     <= full_bar_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (put_acc) mem[wr_ptr_q[PTR_W-1:0]] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; get acknowledges it.
  assign data_out   = mem[rd_ptr_q[PTR_W-1:0]];
  assign data_valid = empty_bar_q;
`else
  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;

  // Registered read port: data_out holds between reads, data_valid pulses once per read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= get_acc;
      if (get_acc) data_out_q <= mem[rd_ptr_q[PTR_W-1:0]];
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`endif

  assign empty_bar    = empty_bar_q;
  assign full_bar     = full_bar_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param (WIDTH=16, DEPTH=8, AF=6, AE=1).
// Expected read data comes from a scoreboard queue filled on accepted puts.
module tb_sync_fifo_param;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int PW = 3;
  localparam int AF = 6;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          put = 1'b0;
  logic          get = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [W-1:0]  data_out;
  logic          data_valid, empty_bar, full_bar, almost_full, almost_empty;
  logic [PW:0]   count;
  logic          overflow, underflow;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .PTR_W(PW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .put(put), .data_in(data_in),
    .get(get), .clr_err(clr_err), .data_out(data_out), .data_valid(data_valid),
    .empty_bar(empty_bar), .full_bar(full_bar), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_err = 0;
  logic [W-1:0] sb_q[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;
  logic [W-1:0] last_out = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    int c;
    c = sb_q.size();
    chk({tag, ".count"},     32'(count),        32'(c));
    chk({tag, ".empty_bar"}, 32'(empty_bar),    32'(c != 0));
    chk({tag, ".full_bar"},  32'(full_bar),     32'(c != D));
    chk({tag, ".afull"},     32'(almost_full),  32'(c >= AF));
    chk({tag, ".aempty"},    32'(almost_empty), 32'(c <= AE));
    chk({tag, ".overflow"},  32'(overflow),     32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow),    32'(m_unf));
  endtask

  // One clock cycle of stimulus; entered and left just after a falling edge.
  task automatic step(input string tag, input logic p, input logic g, input logic f,
                      input logic c, input logic [W-1:0] d);
    logic         pa, ga;
    logic [W-1:0] exp;
    int           n;
    put = p; get = g; flush = f; clr_err = c; data_in = d;
    exp = '0;
    n = sb_q.size();
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, ".fwft_valid"}, 32'(data_valid), 32'(n != 0));
    if (n != 0) chk({tag, ".fwft_head"}, 32'(data_out), 32'(sb_q[0]));
`endif
    @(posedge clk);
    pa = p & ~f & (n != D);
    ga = g & ~f & (n != 0);
    m_ovf = (m_ovf & ~c) | (p & (n == D));
    m_unf = (m_unf & ~c) | (g & (n == 0));
    if (f) sb_q.delete();
    else begin
      if (ga) exp = sb_q.pop_front();
      if (pa) sb_q.push_back(d);
    end
    @(negedge clk);
    put = 1'b0; get = 1'b0; flush = 1'b0; clr_err = 1'b0;
    chk_status(tag);
`ifndef SYNC_FIFO_FWFT_EN
    chk({tag, ".valid"}, 32'(data_valid), 32'(ga));
    if (ga) last_out = exp;
    chk({tag, ".data"}, 32'(data_out), 32'(last_out));
`else
    if (ga) chk({tag, ".fwft_ack"}, 32'(exp), 32'(exp));
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_status("rst");
    chk("rst.valid", 32'(data_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst.data", 32'(data_out), 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);
    chk_status("rst_rel");

    // 1: fill then drain in order
    for (int i = 1; i <= 8; i++) step("t1.put", 1, 0, 0, 0, W'(i));
    for (int i = 1; i <= 8; i++) step("t1.get", 0, 1, 0, 0, '0);

    // 2: pointer wrap
    for (int i = 0; i < 5; i++) step("t2.put", 1, 0, 0, 0, W'(16'h50 + i));
    for (int i = 0; i < 5; i++) step("t2.get", 0, 1, 0, 0, '0);
    for (int i = 0; i < 6; i++) step("t2.put", 1, 0, 0, 0, W'(16'hA0 + i));
    for (int i = 0; i < 3; i++) step("t2.pg", 1, 1, 0, 0, W'(16'hB0 + i));
    for (int i = 0; i < 6; i++) step("t2.get", 0, 1, 0, 0, '0);

    // 3: full with put+get, clr_err, error-wins-over-clear
    for (int i = 0; i < 8; i++) step("t3.fill", 1, 0, 0, 0, W'(16'hC0 + i));
    step("t3.pg_full", 1, 1, 0, 0, 16'hDEAD);
    step("t3.idle", 0, 0, 0, 0, '0);
    step("t3.clr", 0, 0, 0, 1, '0);
    step("t3.refill", 1, 0, 0, 0, 16'hC8);
    step("t3.clr_vs_ovf", 1, 0, 0, 1, 16'hBEEF);
    step("t3.clr2", 0, 0, 0, 1, '0);
    for (int i = 0; i < 8; i++) step("t3.drain", 0, 1, 0, 0, '0);

    // 4: empty with put+get
    step("t4.pg_empty", 1, 1, 0, 0, 16'h1234);
    step("t4.get", 0, 1, 0, 0, '0);
    step("t4.get_empty", 0, 1, 0, 0, '0);
    step("t4.clr", 0, 0, 0, 1, '0);

    // 5: flush overrides put
    for (int i = 0; i < 4; i++) step("t5.put", 1, 0, 0, 0, W'(16'hE0 + i));
    step("t5.flush", 1, 0, 1, 0, 16'h7777);
    step("t5.idle", 0, 0, 0, 0, '0);
    step("t5.put", 1, 0, 0, 0, 16'h4242);
    step("t5.get", 0, 1, 0, 0, '0);

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) step("t6.put", 1, 0, 0, 0, W'(16'hF0 + i));
    step("t6.err", 0, 0, 0, 0, '0);
    #2 reset_n = 1'b0;
    sb_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    last_out = '0;
    #1;
    chk_status("t6.async");
    chk("t6.async.valid", 32'(data_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("t6.async.data", 32'(data_out), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_status("t6.rel");
    step("t6.put", 1, 0, 0, 0, 16'h0001);
    step("t6.idle", 0, 0, 0, 0, '0);
    step("t6.get", 0, 1, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
